// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with registered result and iterative SLL/SRA
//
// Computes ADD/SUB/AND/OR/NOT in one cycle. SLL/SRA move one bit per cycle,
// so a shift by n takes n cycles. Valid/ready handshakes on both sides let
// the pipeline stall around multi-cycle shifts.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous pipeline flush; drops any in-flight op and the output
//   in_valid   opcode/operands valid
//   in_ready   unit can accept an operation this cycle
//   alu_op     0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 NOT, 0110 SLL,
//              1000 SRA; any other code is ADD
//   op_a       first operand / shift source
//   op_b       second operand / shift amount (low SHW bits)
//   out_valid  result register holds a valid result
//   out_ready  downstream consumes the result this cycle
//   result     registered result
//   zero       result == 0
//   sign       result MSB
//   ovf        signed overflow (ADD/SUB only)
//   busy       shift in progress, used by the hazard unit
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             ovf,
    output logic             busy
);

    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b1000;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] work_q;
    logic             sra_q;

    logic             accept;
    logic             is_shift;
    logic             start_shift;
    logic             single_done;
    logic             shift_done;
    logic [SHW-1:0]   shamt;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] work_shifted;

    assign shamt       = op_b[SHW-1:0];
    assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRA);
    assign in_ready    = (state_q == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept      = in_valid && in_ready;
    // A zero-amount shift is just a pass-through, so it takes the single-cycle path.
    assign start_shift = accept && is_shift && (shamt != '0);
    assign single_done = accept && !start_shift;
    assign shift_done  = (state_q == SHIFT) && (cnt_q == SHW'(1));
    assign busy        = (state_q == SHIFT);

    assign work_shifted = sra_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                                : {work_q[WIDTH-2:0], 1'b0};

    // SUB reuses the adder as a + ~b + 1; overflow checks the effective operand signs.
    assign is_sub = (alu_op == OP_SUB);
    assign b_eff  = is_sub ? ~op_b : op_b;
    assign sum    = op_a + b_eff + WIDTH'(is_sub);

    always_comb begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        case (alu_op)
            OP_AND: begin alu_res = op_a & op_b; alu_ovf = 1'b0; end
            OP_OR:  begin alu_res = op_a | op_b; alu_ovf = 1'b0; end
            OP_NOT: begin alu_res = ~op_a;       alu_ovf = 1'b0; end
            OP_SLL,
            OP_SRA: begin alu_res = op_a;        alu_ovf = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_shift) state_d = SHIFT;
                SHIFT:   if (shift_done)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            ovf       <= 1'b0;
            cnt_q     <= '0;
            work_q    <= '0;
            sra_q     <= 1'b0;
        end else if (flush) begin
            // Result/flags are left as-is; clearing out_valid marks them stale.
            out_valid <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (single_done) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                sign      <= alu_res[WIDTH-1];
                ovf       <= alu_ovf;
                out_valid <= 1'b1;
            end else if (shift_done) begin
                result    <= work_shifted;
                zero      <= (work_shifted == '0);
                sign      <= work_shifted[WIDTH-1];
                ovf       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (start_shift) begin
                work_q <= op_a;
                cnt_q  <= shamt;
                sra_q  <= (alu_op == OP_SRA);
            end else if (state_q == SHIFT) begin
                work_q <= work_shifted;
                cnt_q  <= cnt_q - SHW'(1);
            end
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- EX-stage ALU for the 16-bit ThinPad CPU. It consumes the 4-bit ALU opcode produced by the ID-stage ALU-op decoder, together with two operands.
- Single-cycle ops return a registered result. SLL/SRA run as an iterative 1-bit-per-cycle shifter.
- A valid/ready handshake on both sides lets the pipeline stall around multi-cycle shifts.
- Flags feed the T-register/branch logic (CMP and SLT path).

Parameters:
- WIDTH, 16, datapath width. All arithmetic wraps modulo 2^WIDTH.
- SHW, 4, shift-amount width; shamt = op_b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush (branch/exception)
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  unit can accept a new operation this cycle
- alu_op  input  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 NOT, 0110 SLL, 1000 SRA; all other codes behave as ADD
- op_a  input  WIDTH  first operand, or shift source
- op_b  input  WIDTH  second operand, or shift amount (low SHW bits)
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  downstream consumes the result this cycle
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- sign  output  1  result[WIDTH-1]
- ovf  output  1  signed overflow (ADD/SUB only, else 0)
- busy  output  1  state == SHIFT, used by the hazard unit to stall

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out_valid=0; result=0; zero=0; sign=0; ovf=0; shift counter=0; work register=0.
- States:
  - IDLE: may accept new operations.
  - SHIFT: iterating a shift.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready, sampled at the rising edge (T0).
- Non-shift op, or shift with shamt==0, accepted at T0:
  - At T0, result/flags load the computed value and out_valid<=1. Latency 1.
  - shamt==0 gives result=op_a.
- ADD/SUB:
  - SUB computes op_a + ~op_b + 1.
  - ovf = operands' sign agrees (ADD: a,b; SUB: a,~b) and result sign differs.
- NOT ignores op_b. AND/OR are bitwise.
- Shift with shamt=n>=1, accepted at T0:
  - At T0: work<=op_a, cnt<=n, op latched, state<=SHIFT. out_valid is unchanged by the accept itself (cleared if out_ready).
  - Each edge in SHIFT with cnt>1: work<=work<<1 (SLL, zero fill) or {work[MSB],work[MSB:1]} (SRA, sign fill); cnt<=cnt-1.
  - Edge in SHIFT with cnt==1: result<=final shifted value; flags updated (ovf=0); out_valid<=1; state<=IDLE.
  - Total latency = n cycles (out_valid rises at edge T0+n).
- Output hold:
  - While out_valid && !out_ready, result and flags are held stable and in_ready=0.
  - On out_valid && out_ready with no new completion that edge, out_valid<=0.
- Simultaneous consume and new single-cycle accept: the result register is overwritten and out_valid stays 1 (back-to-back throughput of 1 op/cycle).
- The output register is always empty when a SHIFT completes, because accept required it free and nothing else writes it during SHIFT.
- flush (synchronous, priority over everything except reset):
  - state<=IDLE; out_valid<=0; cnt<=0.
  - Any in-flight shift is discarded.
  - result/flags keep their old values but are invalid.
- in_valid while in SHIFT is ignored (in_ready=0). Upstream must hold its request.
- Reset asserted mid-shift returns immediately to the reset values above, with no partial result.

Test Plan:
- ADD overflow: ADD 0x7FFF+0x0001 -> next cycle result=0x8000, sign=1, ovf=1, zero=0, out_valid=1.
- SUB equality and NOT:
  - SUB 0x1234-0x1234 -> result=0x0000, zero=1, ovf=0.
  - NOT 0x00FF -> 0xFF00.
- Back-to-back throughput: AND 0xF0F0&0x0FF0 then OR 0x0F00|0x00F0 with out_ready=1 -> results 0x00F0, 0x0FF0 on consecutive cycles, in_ready never drops.
- SRA, 3-cycle: SRA 0x8010 by 3 -> busy=1 and in_ready=0 for 3 cycles; out_valid at T0+3 with result=0xF002, sign=1.
- SLL edge amounts:
  - SLL 0x0001 by 15 -> 0x8000 at T0+15.
  - SLL 0xABCD by 0 -> 0xABCD at T0+1.
- Stall and flush:
  - out_ready=0 holding 0x1111 -> result stable, in_ready=0 for 5 cycles.
  - flush during SLL by 8 at T0+4 -> out_valid stays 0, state IDLE, in_ready=1 next cycle.
  - rst pulse mid-shift -> all outputs 0 immediately.
